button_pulser: RTL and testbench

Input conditioner that produces the single-cycle control pulses consumed by the LED counter block (`mode_switch`, `ext_counter`) from raw, bouncing, asynchronous push-buttons. Each channel synchronises its button, debounces press and release, emits one `pulse_out` cycle per accepted press, and optionally auto-repeats while the button is held. Sits between board pins and the LED logic, with one channel per control input.

---
 rtl/button_pulser.sv | 116 +++++++++++
 tb/tb_button_pulser.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/button_pulser.sv
// Per-channel push-button conditioner: 2-flop synchroniser, press/release debounce,
// one-cycle press pulse and optional auto-repeat while held.
module button_pulser #(
  parameter int unsigned NO_OF_BUTTONS   = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NO_OF_BUTTONS-1:0] btn_in,
  input  logic                     repeat_en,
  output logic [NO_OF_BUTTONS-1:0] pulse_out,
  output logic [NO_OF_BUTTONS-1:0] level_out
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_DELAY;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  for (genvar i = 0; i < NO_OF_BUTTONS; i++) begin : g_ch
    logic             sync_q1;
    logic             btn_sync;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pulse_q;
    logic             level_q;

    // Two-flop synchroniser for the asynchronous button pin
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_q1  <= 1'b0;
        btn_sync <= 1'b0;
      end else begin
        sync_q1  <= btn_in[i];
        btn_sync <= sync_q1;
      end
    end

    // Debounce / repeat FSM; any opposite-level sample during a wait restarts it
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state   <= RELEASED;
        cnt     <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state)
          RELEASED: begin
            if (btn_sync) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!btn_sync) begin
              state <= RELEASED;
            end else if (cnt == DEB_LAST) begin
              state   <= HELD;
              level_q <= 1'b1;
              pulse_q <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HELD: begin
            if (!btn_sync) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (!repeat_en) begin
              cnt <= '0;
            end else if (cnt == REP_LAST) begin
              pulse_q <= 1'b1;
              cnt     <= REP_RELOAD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RELEASE_WAIT: begin
            // Returning to HELD restarts repeat timing but never re-pulses
            if (btn_sync) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state   <= RELEASED;
              level_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign pulse_out[i] = pulse_q;
    assign level_out[i] = level_q;
  end

endmodule

// File: tb/tb_button_pulser.sv
// Directed bench for button_pulser with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_button_pulser;

  localparam int unsigned NB = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NB-1:0] btn_in;
  logic          repeat_en;
  logic [NB-1:0] pulse_out;
  logic [NB-1:0] level_out;

  int errors = 0;
  int checks = 0;

  button_pulser #(
    .NO_OF_BUTTONS  (NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .btn_in   (btn_in),
    .repeat_en(repeat_en),
    .pulse_out(pulse_out),
    .level_out(level_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop all buttons; level must fall on release edge 6 with no pulse
  task automatic release_all(input string tag, input logic [NB-1:0] held);
    btn_in    = '0;
    repeat_en = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      chk($sformatf("%s_rel_pulse e%0d", tag, e), pulse_out, 2'b00);
      chk($sformatf("%s_rel_level e%0d", tag, e), level_out, (e >= 6) ? 2'b00 : held);
    end
  endtask

  initial begin
    resetn    = 1'b1;
    btn_in    = '0;
    repeat_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("reset_pulse", pulse_out, 2'b00);
    chk("reset_level", level_out, 2'b00);
    step();
    step();
    resetn = 1'b1;

    for (int e = 0; e < 20; e++) begin
      step();
      chk($sformatf("idle_pulse e%0d", e), pulse_out, 2'b00);
      chk($sformatf("idle_level e%0d", e), level_out, 2'b00);
    end

    // Clean press, no repeat
    btn_in = 2'b01;
    for (int e = 0; e < 30; e++) begin
      step();
      chk($sformatf("press_pulse e%0d", e), pulse_out, (e == 6) ? 2'b01 : 2'b00);
      chk($sformatf("press_level e%0d", e), level_out, (e >= 6) ? 2'b01 : 2'b00);
    end
    release_all("press", 2'b01);

    // Bounce: high 3, low 1, high 2, low 20
    for (int e = 0; e < 26; e++) begin
      btn_in = (e < 3 || e == 4 || e == 5) ? 2'b01 : 2'b00;
      step();
      chk($sformatf("bounce_pulse e%0d", e), pulse_out, 2'b00);
      chk($sformatf("bounce_level e%0d", e), level_out, 2'b00);
    end
    btn_in = 2'b01;
    for (int e = 0; e < 10; e++) begin
      step();
      chk($sformatf("after_bounce_pulse e%0d", e), pulse_out, (e == 6) ? 2'b01 : 2'b00);
      chk($sformatf("after_bounce_level e%0d", e), level_out, (e >= 6) ? 2'b01 : 2'b00);
    end
    release_all("bounce", 2'b01);

    // Auto-repeat held: press at 6, repeats at 14, then every 3
    btn_in    = 2'b01;
    repeat_en = 1'b1;
    for (int e = 0; e < 25; e++) begin
      step();
      chk($sformatf("rpt_pulse e%0d", e), pulse_out,
          (e == 6 || e == 14 || e == 17 || e == 20 || e == 23) ? 2'b01 : 2'b00);
      chk($sformatf("rpt_level e%0d", e), level_out, (e >= 6) ? 2'b01 : 2'b00);
    end
    release_all("rpt", 2'b01);

    // Auto-repeat with repeat_en dropped at edge 18
    btn_in = 2'b01;
    for (int e = 0; e < 25; e++) begin
      repeat_en = (e < 18);
      step();
      chk($sformatf("rptoff_pulse e%0d", e), pulse_out,
          (e == 6 || e == 14 || e == 17) ? 2'b01 : 2'b00);
      chk($sformatf("rptoff_level e%0d", e), level_out, (e >= 6) ? 2'b01 : 2'b00);
    end
    release_all("rptoff", 2'b01);

    // Release bounce while HELD: low for edges 10-11, back to HELD at 14, repeat at 22
    repeat_en = 1'b1;
    for (int e = 0; e < 25; e++) begin
      btn_in = (e == 10 || e == 11) ? 2'b00 : 2'b01;
      step();
      chk($sformatf("relb_pulse e%0d", e), pulse_out, (e == 6 || e == 22) ? 2'b01 : 2'b00);
      chk($sformatf("relb_level e%0d", e), level_out, (e >= 6) ? 2'b01 : 2'b00);
    end
    release_all("relb", 2'b01);

    // Simultaneous press on both channels
    btn_in = 2'b11;
    for (int e = 0; e < 10; e++) begin
      step();
      chk($sformatf("both_pulse e%0d", e), pulse_out, (e == 6) ? 2'b11 : 2'b00);
      chk($sformatf("both_level e%0d", e), level_out, (e >= 6) ? 2'b11 : 2'b00);
    end

    // Asynchronous reset mid-cycle clears outputs immediately
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_pulse", pulse_out, 2'b00);
    chk("async_rst_level", level_out, 2'b00);
    btn_in = 2'b00;
    step();
    step();
    resetn = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      chk($sformatf("post_rst_pulse e%0d", e), pulse_out, 2'b00);
      chk($sformatf("post_rst_level e%0d", e), level_out, 2'b00);
    end

    // Reset during PRESS_WAIT aborts the pending press pulse
    btn_in = 2'b01;
    for (int e = 0; e < 4; e++) begin
      step();
      chk($sformatf("abort_pre_pulse e%0d", e), pulse_out, 2'b00);
      chk($sformatf("abort_pre_level e%0d", e), level_out, 2'b00);
    end
    resetn = 1'b0;
    #1;
    chk("abort_rst_pulse", pulse_out, 2'b00);
    btn_in = 2'b00;
    step();
    resetn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      chk($sformatf("abort_pulse e%0d", e), pulse_out, 2'b00);
      chk($sformatf("abort_level e%0d", e), level_out, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
